// File: rtl/core_wb_arbiter_if.sv
// Wishbone pipelined bus bundle shared by the fetch/MAU masters and the slave.
// 'master' is the view of a bus initiator, 'slave' the view of a target.
interface core_wb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_mo;
    logic [DW/8-1:0] sel;
    logic            ack;
    logic            err;
    logic            stall;
    logic [DW-1:0]   dat_so;

    modport master (
        output cyc, stb, we, adr, dat_mo, sel,
        input  ack, err, stall, dat_so
    );

    modport slave (
        input  cyc, stb, we, adr, dat_mo, sel,
        output ack, err, stall, dat_so
    );
endinterface

// File: rtl/core_wb_arbiter.sv
// Two-master Wishbone arbiter: fetch (m0) and MAU (m1) share one slave bus.
// Burst-held grant, round-robin on contention, per-transfer ack watchdog.
module core_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    core_wb_arbiter_if.slave        m0,
    core_wb_arbiter_if.slave        m1,
    core_wb_arbiter_if.master       s,
    output logic [1:0]              grant
);
    localparam int WW = $clog2(TIMEOUT);

    // Encoding doubles as the one-hot grant vector
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    logic [1:0]      state_q, state_d;
    logic            last_q, last_d;
    logic [WW-1:0]   wdog_q, wdog_d;

    logic            g0, g1;
    logic            own_cyc, own_stb, own_we;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [DW/8-1:0] own_sel;
    logic            wdog_fire;

    assign g0    = (state_q == ST_GNT0);
    assign g1    = (state_q == ST_GNT1);
    assign grant = state_q;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        case (state_q)
            ST_GNT0: begin
                own_cyc = m0.cyc;
                own_stb = m0.stb;
                own_we  = m0.we;
                own_adr = m0.adr;
                own_dat = m0.dat_mo;
                own_sel = m0.sel;
            end
            ST_GNT1: begin
                own_cyc = m1.cyc;
                own_stb = m1.stb;
                own_we  = m1.we;
                own_adr = m1.adr;
                own_dat = m1.dat_mo;
                own_sel = m1.sel;
            end
            default: ;
        endcase
    end

    assign wdog_fire = own_stb & (wdog_q == WW'(TIMEOUT - 1));

    // Strobe is withheld on the fire cycle so the slave sees no new transfer
    assign s.cyc    = own_cyc;
    assign s.stb    = own_stb & ~wdog_fire;
    assign s.we     = own_we;
    assign s.adr    = own_adr;
    assign s.dat_mo = own_dat;
    assign s.sel    = own_sel;

    assign m0.ack    = g0 & s.ack;
    assign m0.err    = g0 & wdog_fire & ~s.ack;
    assign m0.stall  = g0 ? s.stall : 1'b1;
    assign m0.dat_so = s.dat_so;

    assign m1.ack    = g1 & s.ack;
    assign m1.err    = g1 & wdog_fire & ~s.ack;
    assign m1.stall  = g1 ? s.stall : 1'b1;
    assign m1.dat_so = s.dat_so;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc & m1.cyc)
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                else if (m1.cyc)
                    state_d = ST_GNT1;
                else if (m0.cyc)
                    state_d = ST_GNT0;
            end
            ST_GNT0: begin
                if (!m0.cyc) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end
            end
            ST_GNT1: begin
                if (!m1.cyc) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if ((state_d != state_q) || !own_stb || s.ack || wdog_fire)
            wdog_d = '0;
        else
            wdog_d = wdog_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end
endmodule

// File: tb/tb_core_wb_arbiter.sv
// Bench for core_wb_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_core_wb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] grant;

    core_wb_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    core_wb_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    core_wb_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    core_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant)
    );

    int checks   = 0;
    int failures = 0;

    logic            cyc_v [2];
    logic            stb_v [2];
    logic            we_v  [2];
    logic [AW-1:0]   adr_v [2];
    logic [DW-1:0]   dat_v [2];
    logic [DW/8-1:0] sel_v [2];
    logic            sack, sstall;
    logic [DW-1:0]   sdat;

    // Reference: who owns the bus (-1 none), who owned it last, stalled-strobe age
    int own, last, wd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        m0_if.cyc = cyc_v[0]; m0_if.stb = stb_v[0]; m0_if.we = we_v[0];
        m0_if.adr = adr_v[0]; m0_if.dat_mo = dat_v[0]; m0_if.sel = sel_v[0];
        m1_if.cyc = cyc_v[1]; m1_if.stb = stb_v[1]; m1_if.we = we_v[1];
        m1_if.adr = adr_v[1]; m1_if.dat_mo = dat_v[1]; m1_if.sel = sel_v[1];
        s_if.ack = sack; s_if.stall = sstall; s_if.dat_so = sdat;
        s_if.err = 1'b0;
    endtask

    task automatic set(input logic c0, input logic s0, input logic c1,
                       input logic s1, input logic ack, input logic stl);
        cyc_v[0] = c0; stb_v[0] = s0;
        cyc_v[1] = c1; stb_v[1] = s1;
        sack = ack; sstall = stl;
        for (int i = 0; i < 2; i++) begin
            we_v[i]  = 1'($urandom);
            adr_v[i] = $urandom;
            dat_v[i] = $urandom;
            sel_v[i] = 4'($urandom);
        end
        sdat = $urandom;
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        logic ostb, fire;
        logic [1:0] ack_g, err_g, stl_g;
        eg   = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        ostb = (own >= 0) ? stb_v[own] : 1'b0;
        fire = ostb && (wd == TO - 1);
        chk("grant", 64'(grant), 64'(eg));
        chk("s_cyc", 64'(s_if.cyc), 64'((own >= 0) ? cyc_v[own] : 1'b0));
        chk("s_stb", 64'(s_if.stb), 64'(ostb && !fire));
        if (own >= 0) begin
            chk("s_we", 64'(s_if.we), 64'(we_v[own]));
            chk("s_adr", 64'(s_if.adr), 64'(adr_v[own]));
            chk("s_dat_mo", 64'(s_if.dat_mo), 64'(dat_v[own]));
            chk("s_sel", 64'(s_if.sel), 64'(sel_v[own]));
        end else begin
            chk("s_bus_idle", 64'({s_if.we, s_if.sel, s_if.adr}), 64'd0);
        end
        ack_g = {m1_if.ack, m0_if.ack};
        err_g = {m1_if.err, m0_if.err};
        stl_g = {m1_if.stall, m0_if.stall};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_ack", i), 64'(ack_g[i]),
                64'(own == i && sack));
            chk($sformatf("m%0d_err", i), 64'(err_g[i]),
                64'(own == i && fire && !sack));
            chk($sformatf("m%0d_stall", i), 64'(stl_g[i]),
                64'((own == i) ? sstall : 1'b1));
        end
        chk("m0_dat_so", 64'(m0_if.dat_so), 64'(sdat));
        chk("m1_dat_so", 64'(m1_if.dat_so), 64'(sdat));
    endtask

    task automatic model_update();
        int nxt;
        logic ostb, fire;
        ostb = (own >= 0) ? stb_v[own] : 1'b0;
        fire = ostb && (wd == TO - 1);
        if (rst) begin
            own = -1; last = 0; wd = 0;
            return;
        end
        nxt = own;
        if (own < 0) begin
            if (cyc_v[0] && cyc_v[1]) nxt = (last == 0) ? 1 : 0;
            else if (cyc_v[1])        nxt = 1;
            else if (cyc_v[0])        nxt = 0;
        end else if (!cyc_v[own]) begin
            last = own;
            nxt  = -1;
        end
        if (nxt != own || !ostb || sack || fire) wd = 0;
        else wd = wd + 1;
        own = nxt;
    endtask

    task automatic step();
        apply();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0);
        apply();
        @(posedge clk);
        own = -1; last = 0; wd = 0;
        @(negedge clk);
        step();
        rst = 1'b0;
        step();

        // MAU single read, ack two cycles after strobe
        set(0, 0, 1, 1, 0, 0); step();
        set(0, 0, 1, 1, 0, 0); step();
        set(0, 0, 1, 0, 0, 0); step();
        set(0, 0, 1, 0, 1, 0); step();
        set(0, 0, 0, 0, 0, 0); step();
        step();

        // Repeated contention: owners must alternate
        for (int r = 0; r < 4; r++) begin
            set(1, 1, 1, 1, 0, 0); step();
            set(1, 1, 1, 1, 1, 0); step();
            set(1, 0, 1, 0, 0, 0); step();
            if (own == 1) set(1, 0, 0, 0, 0, 0);
            else          set(0, 0, 1, 0, 0, 0);
            step();
            set(0, 0, 0, 0, 0, 0); step();
            step();
        end

        // Fetch burst with MAU request arriving mid-burst
        set(1, 1, 0, 0, 0, 0); step();
        set(1, 1, 0, 0, 1, 0); step();
        set(1, 1, 1, 1, 1, 1); step();
        set(1, 1, 1, 1, 1, 0); step();
        set(1, 0, 1, 1, 0, 0); step();
        set(0, 0, 1, 1, 0, 0); step();
        set(0, 0, 1, 1, 1, 0); step();
        set(0, 0, 0, 0, 0, 0); step();
        step();

        // Dead slave: watchdog fires, grant held until cyc drops
        for (int i = 0; i < TO + 4; i++) begin
            set(1, 1, 0, 0, 0, 0); step();
        end
        set(0, 0, 0, 0, 0, 0); step();
        step();

        // Reset while MAU holds the bus with a strobe pending
        set(0, 0, 1, 1, 0, 0); step();
        step();
        rst = 1'b1;
        set(0, 0, 1, 1, 1, 0); step();
        rst = 1'b0;
        set(0, 0, 0, 0, 1, 0); step();
        set(0, 0, 0, 0, 0, 0); step();

        // Random traffic with periodic dead-slave windows
        for (int n = 0; n < 1500; n++) begin
            logic c0, c1, s0, s1, ack, stl;
            bit dead;
            dead = ((n / 60) % 3) == 2;
            c0 = cyc_v[0] ? ($urandom_range(0, 5) != 0)
                          : ($urandom_range(0, 3) == 0);
            c1 = cyc_v[1] ? ($urandom_range(0, 5) != 0)
                          : ($urandom_range(0, 3) == 0);
            s0 = c0 && ($urandom_range(0, 3) != 0);
            s1 = c1 && ($urandom_range(0, 3) != 0);
            ack = !dead && ($urandom_range(0, 2) == 0);
            stl = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            set(c0, s0, c1, s1, ack, stl);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
